// File: rtl/pcs_scr_pkg.sv
// pcs_scr_pkg
//   Shared constants and types for the 40G/100G PCS scrambler pipeline.
//   Polynomial g(x) = x^58 + x^39 + 1; the LFSR state holds the last 58
//   scrambled bits with bit 0 the most recent, so the x^39 and x^58 taps
//   sit at state bits TAP_A-1 and TAP_B-1.
package pcs_scr_pkg;

    localparam int LFSR_WIDTH = 58;
    localparam int TAP_A      = 39;
    localparam int TAP_B      = 58;

    localparam logic [LFSR_WIDTH-1:0] SEED_DEFAULT = 58'h3FF_FFFF_FFFF_FFFF;

    // Occupancy of the output/skid register pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pcs_scr_lfsr_comb.sv
// pcs_scr_lfsr_comb
//   Purely combinational unroll of DATA_WIDTH serial steps of the
//   multiplicative (self-synchronising) scrambler/descrambler.
//   Bit 0 of the payload is processed first.
//
// Ports
//   state_in   : LFSR state before the beat (bit 0 = most recent bit)
//   data_in    : payload to scramble / descramble
//   data_out   : processed payload
//   state_out  : LFSR state after absorbing the beat's scrambled bits
//
// Parameters
//   DATA_WIDTH : payload bits per beat (8..256)
//   DESCRAMBLE : 0 = scrambler (state absorbs produced bits),
//                1 = descrambler (state absorbs received bits)
module pcs_scr_lfsr_comb
    import pcs_scr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DESCRAMBLE = 0
) (
    input  logic [LFSR_WIDTH-1:0] state_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LFSR_WIDTH-1:0] state_out
);

    always_comb begin
        logic [LFSR_WIDTH-1:0] s;
        logic                  fb;
        s        = state_in;
        fb       = 1'b0;
        data_out = '0;
        for (int n = 0; n < DATA_WIDTH; n++) begin
            fb          = s[TAP_A-1] ^ s[TAP_B-1];
            data_out[n] = data_in[n] ^ fb;
            // The state always tracks the scrambled stream: for the
            // scrambler that is what we produce, for the descrambler it
            // is what we receive.
            s = {s[LFSR_WIDTH-2:0], (DESCRAMBLE != 0) ? data_in[n] : data_out[n]};
        end
        state_out = s;
    end

endmodule

// File: rtl/pcs_scrambler_pipe.sv
// pcs_scrambler_pipe
//   Parametrised x^58 + x^39 + 1 scrambler / self-synchronising
//   descrambler with a valid/ready input and a 2-entry skid buffer on
//   the output. Sync headers pass through untouched; a bypass flag
//   passes one beat's payload unscrambled.
//
// Ports
//   CLK, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : input handshake (in_ready is registered)
//   in_data, in_hdr          : payload (bit 0 first on the wire), header
//   in_bypass                : forward this beat's payload unchanged
//   out_valid / out_ready    : output handshake
//   out_data, out_hdr        : processed payload and aligned header
//   seed_load, seed_value    : only with PCS_SCR_SEED_LOAD_EN defined;
//                              loads the LFSR state at the clock edge
//
// Optional build macro: PCS_SCR_SEED_LOAD_EN
module pcs_scrambler_pipe
    import pcs_scr_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DESCRAMBLE = 0,
    parameter logic [LFSR_WIDTH-1:0] SEED       = SEED_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_hdr,
    input  logic                  in_bypass,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_hdr
`ifdef PCS_SCR_SEED_LOAD_EN
    ,
    input  logic                  seed_load,
    input  logic [LFSR_WIDTH-1:0] seed_value
`endif
);

    logic [LFSR_WIDTH-1:0] lfsr_reg, lfsr_next;
    logic [LFSR_WIDTH-1:0] scr_state;
    logic [DATA_WIDTH-1:0] scr_data;
    logic [DATA_WIDTH-1:0] beat_data;

    skid_state_t           skid_state_reg, skid_state_next;
    logic                  in_ready_reg, in_ready_next;
    logic [DATA_WIDTH-1:0] out_data_reg, skid_data_reg;
    logic [1:0]            out_hdr_reg, skid_hdr_reg;

    logic beat_accept, beat_pop, lfsr_absorb;
    logic load_out_new, load_out_skid, load_skid;

    pcs_scr_lfsr_comb #(
        .DATA_WIDTH (DATA_WIDTH),
        .DESCRAMBLE (DESCRAMBLE)
    ) u_lfsr (
        .state_in  (lfsr_reg),
        .data_in   (in_data),
        .data_out  (scr_data),
        .state_out (scr_state)
    );

    assign beat_accept = in_valid && in_ready_reg;
    assign beat_pop    = out_valid && out_ready;
    assign beat_data   = in_bypass ? in_data : scr_data;

    // A bypassed beat never reaches the wire scrambled on the scrambler
    // side, so its state holds; the descrambler keeps absorbing the
    // received bits so it stays locked to the line.
    assign lfsr_absorb = beat_accept && ((DESCRAMBLE != 0) || !in_bypass);

    always_comb begin
        lfsr_next = lfsr_reg;
        if (lfsr_absorb) begin
            lfsr_next = scr_state;
        end
`ifdef PCS_SCR_SEED_LOAD_EN
        // The same-cycle beat has already been computed from lfsr_reg.
        if (seed_load) begin
            lfsr_next = seed_value;
        end
`endif
    end

    always_comb begin
        skid_state_next = skid_state_reg;
        load_out_new    = 1'b0;
        load_out_skid   = 1'b0;
        load_skid       = 1'b0;
        case (skid_state_reg)
            EMPTY: begin
                if (beat_accept) begin
                    skid_state_next = ONE;
                    load_out_new    = 1'b1;
                end
            end
            ONE: begin
                if (beat_accept && beat_pop) begin
                    load_out_new = 1'b1;
                end else if (beat_accept) begin
                    skid_state_next = FULL;
                    load_skid       = 1'b1;
                end else if (beat_pop) begin
                    skid_state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (beat_pop) begin
                    skid_state_next = ONE;
                    load_out_skid   = 1'b1;
                end
            end
            default: begin
                skid_state_next = EMPTY;
            end
        endcase
    end

    // Registering the decode keeps out_ready off the in_ready path.
    assign in_ready_next = (skid_state_next != FULL);

    always_ff @(posedge CLK) begin
        if (rst) begin
            skid_state_reg <= EMPTY;
            in_ready_reg   <= 1'b1;
            lfsr_reg       <= SEED;
            out_data_reg   <= '0;
            out_hdr_reg    <= '0;
            skid_data_reg  <= '0;
            skid_hdr_reg   <= '0;
        end else begin
            skid_state_reg <= skid_state_next;
            in_ready_reg   <= in_ready_next;
            lfsr_reg       <= lfsr_next;
            if (load_out_new) begin
                out_data_reg <= beat_data;
                out_hdr_reg  <= in_hdr;
            end else if (load_out_skid) begin
                out_data_reg <= skid_data_reg;
                out_hdr_reg  <= skid_hdr_reg;
            end
            if (load_skid) begin
                skid_data_reg <= beat_data;
                skid_hdr_reg  <= in_hdr;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (skid_state_reg != EMPTY);
    assign out_data  = out_data_reg;
    assign out_hdr   = out_hdr_reg;

endmodule

// File: tb/tb_pcs_scrambler_pipe.sv
// tb_pcs_scrambler_pipe
//   Six DUT instances: scrambler/descrambler pairs at 64, 32 and 128 bits
//   (even index = scrambler, odd = descrambler). The scrambler reference
//   works on the serial stream y[n] = x[n] ^ y[n-39] ^ y[n-58]; the
//   descrambler is checked by looping scrambler output back to it and
//   comparing with the original source. Optional macro:
//   PCS_SCR_SEED_LOAD_EN.
module tb_pcs_scrambler_pipe;
    import pcs_scr_pkg::*;

    localparam int N = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic [N-1:0] in_v  = '0;
    logic [N-1:0] in_b  = '0;
    logic [N-1:0] o_rdy = '0;
    logic [N-1:0] i_rdy;
    logic [N-1:0] o_v;
    logic [255:0] in_d [N];
    logic [1:0]   in_h [N];
    logic [255:0] o_d  [N];
    logic [1:0]   o_h  [N];
`ifdef PCS_SCR_SEED_LOAD_EN
    logic [N-1:0] sl = '0;
    logic [57:0]  sv [N];
`endif

    int n_vec = 0;
    int n_err = 0;
    bit rand_ready = 1'b0;

    logic [257:0] expq [N][$];
    logic [257:0] cap  [N][$];
    logic [257:0] srcq [N][$];
    bit           yh   [N][$];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int W = (gi < 2) ? 64 : (gi < 4) ? 32 : 128;
        localparam int D = gi % 2;
        logic [W-1:0] od;
        pcs_scrambler_pipe #(
            .DATA_WIDTH (W),
            .DESCRAMBLE (D)
        ) u_dut (
            .CLK       (clk),
            .rst       (rst),
            .in_valid  (in_v[gi]),
            .in_ready  (i_rdy[gi]),
            .in_data   (in_d[gi][W-1:0]),
            .in_hdr    (in_h[gi]),
            .in_bypass (in_b[gi]),
            .out_valid (o_v[gi]),
            .out_ready (o_rdy[gi]),
            .out_data  (od),
            .out_hdr   (o_h[gi])
`ifdef PCS_SCR_SEED_LOAD_EN
            ,
            .seed_load (sl[gi]),
            .seed_value(sv[gi])
`endif
        );
        assign o_d[gi] = {{(256-W){1'b0}}, od};
    end

    function automatic int wid(int i);
        if (i < 2) return 64;
        if (i < 4) return 32;
        return 128;
    endfunction

    function automatic logic [255:0] mask(logic [255:0] d, int w);
        return d & ((256'd1 << w) - 256'd1);
    endfunction

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    // History of the scrambled stream, oldest first; seeded with the 58
    // bits preceding y[0] (seed bit 57 is y[-58], bit 0 is y[-1]).
    function automatic void model_reset(int i, logic [57:0] seed);
        yh[i].delete();
        for (int k = 57; k >= 0; k--) yh[i].push_back(seed[k]);
    endfunction

    function automatic logic [255:0] scr_model(int i, logic [255:0] x);
        logic [255:0] y;
        bit           b;
        int           sz;
        y = '0;
        for (int n = 0; n < wid(i); n++) begin
            sz = yh[i].size();
            b  = x[n] ^ yh[i][sz-39] ^ yh[i][sz-58];
            y[n] = b;
            yh[i].push_back(b);
            void'(yh[i].pop_front());
        end
        return y;
    endfunction

    task automatic check(string tag, logic [257:0] obs, logic [257:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(string tag);
        n_vec++;
        n_err++;
        $error("FAIL %s: observed timeout expected progress", tag);
    endtask

    // Drive one beat; returns at the point where it is committed to be
    // accepted on the next rising edge. Bypass beats expect in_data back.
    task automatic send(int i, logic [255:0] d, logic [1:0] h, bit b, logic [255:0] exp);
        int guard;
        guard = 0;
        @(negedge clk); #1;
        in_v[i] = 1'b1;
        in_d[i] = d;
        in_h[i] = h;
        in_b[i] = b;
        if (rand_ready) o_rdy[i] = ($urandom_range(0, 3) != 0);
        while (!i_rdy[i] && guard < 100) begin
            @(negedge clk); #1;
            if (rand_ready) o_rdy[i] = ($urandom_range(0, 3) != 0);
            guard++;
        end
        if (!i_rdy[i]) fail_timeout("send");
        else expq[i].push_back({h, b ? mask(in_d[i], wid(i)) : mask(exp, wid(i))});
    endtask

    task automatic drain(int i);
        int guard;
        guard = 0;
        @(negedge clk); #1;
        in_v[i]  = 1'b0;
        in_b[i]  = 1'b0;
        o_rdy[i] = 1'b1;
        while (expq[i].size() > 0 && guard < 400) begin
            @(negedge clk); #1;
            guard++;
        end
        if (expq[i].size() > 0) fail_timeout("drain");
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst     = 1'b1;
        in_v    = '0;
        in_v[0] = 1'b1;   // must be ignored while in reset
        in_b    = '0;
        o_rdy   = '0;
`ifdef PCS_SCR_SEED_LOAD_EN
        sl = '0;
`endif
        @(negedge clk); #1;
        rst  = 1'b0;
        in_v = '0;
        for (int i = 0; i < N; i++) begin
            expq[i].delete();
            cap[i].delete();
            srcq[i].delete();
            model_reset(i, SEED_DEFAULT);
        end
    endtask

    task automatic loopback(int si, int nbeats);
        logic [255:0] x;
        logic [1:0]   h;
        logic [257:0] c, s;
        rand_ready = 1'b1;
        for (int k = 0; k < nbeats; k++) begin
            x = rnd();
            h = 2'($urandom_range(0, 3));
            send(si, x, h, 1'b0, scr_model(si, x));
            srcq[si].push_back({h, mask(x, wid(si))});
        end
        drain(si);
        for (int k = 0; k < cap[si].size(); k++) begin
            c = cap[si][k];
            s = srcq[si][k];
            send(si + 1, c[255:0], c[257:256], 1'b0, s[255:0]);
        end
        drain(si + 1);
        rand_ready = 1'b0;
        check($sformatf("loop%0d_count", wid(si)), 258'(cap[si+1].size()), 258'(srcq[si].size()));
    endtask

    // Output monitor: every popped beat must match the head of its queue.
    initial begin
        forever begin
            @(negedge clk); #2;
            for (int i = 0; i < N; i++) begin
                if (!rst && o_v[i] && o_rdy[i]) begin
                    if (expq[i].size() == 0) begin
                        n_vec++;
                        n_err++;
                        $error("FAIL unexpected_beat[%0d]: observed %h expected none", i, {o_h[i], o_d[i]});
                    end else begin
                        check($sformatf("beat[%0d]", i), {o_h[i], o_d[i]}, expq[i].pop_front());
                    end
                    cap[i].push_back({o_h[i], o_d[i]});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] x;
        logic [257:0] c, s;
        logic [1:0]   h;
        int           acc;
        bit           pending;
        localparam logic [63:0] ZERO_BEAT = 64'h03FF_FF80_0000_0000;
        localparam logic [63:0] BYP_WORD  = 64'hDEAD_BEEF_0123_4567;

        for (int i = 0; i < N; i++) begin
            in_d[i] = '0;
            in_h[i] = '0;
`ifdef PCS_SCR_SEED_LOAD_EN
            sv[i] = '0;
`endif
        end
        x = '0;
        h = '0;

        // Reset state of every instance
        do_reset();
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_out_valid[%0d]", i), 258'(o_v[i]), 258'(0));
            check($sformatf("rst_in_ready[%0d]", i), 258'(i_rdy[i]), 258'(1));
            check($sformatf("rst_out_data[%0d]", i), 258'(o_d[i]), 258'(0));
            check($sformatf("rst_out_hdr[%0d]", i), 258'(o_h[i]), 258'(0));
        end

        // First zero beat after reset gives the known seed pattern
        o_rdy = '1;
        send(0, '0, 2'b01, 1'b0, scr_model(0, '0));
        srcq[0].push_back({2'b01, 256'd0});
        drain(0);
        c = cap[0][0];
        check("first_zero_beat", c, {2'b01, 192'd0, ZERO_BEAT});

        // Random loopbacks at 64, 32 and 128 bits
        loopback(0, 1000);
        loopback(2, 200);
        loopback(4, 200);

        // Back-pressure: out_ready low for 5 cycles under continuous valid
        do_reset();
        acc     = 0;
        pending = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk); #1;
            if (!pending) begin
                x = rnd();
                h = 2'($urandom_range(0, 3));
                in_v[0] = 1'b1;
                in_d[0] = x;
                in_h[0] = h;
                in_b[0] = 1'b0;
                pending = 1'b1;
            end
            if (i_rdy[0]) begin
                acc++;
                expq[0].push_back({h, mask(scr_model(0, x), 64)});
                pending = 1'b0;
            end
        end
        check("bp_accepts", 258'(acc), 258'(2));
        check("bp_in_ready", 258'(i_rdy[0]), 258'(0));
        check("bp_out_valid", 258'(o_v[0]), 258'(1));
        c = expq[0][0];
        check("bp_head_held", {o_h[0], o_d[0]}, c);
        drain(0);
        check("bp_drained", 258'(cap[0].size()), 258'(2));

        // Scrambler bypass: payload unchanged, state held
        do_reset();
        o_rdy = '1;
        x = rnd();
        send(0, x, 2'b10, 1'b0, scr_model(0, x));
        send(0, {192'd0, BYP_WORD}, 2'b01, 1'b1, '0);
        send(0, '0, 2'b01, 1'b0, scr_model(0, '0));
        drain(0);
        c = cap[0][1];
        check("bypass_word", c, {2'b01, 192'd0, BYP_WORD});

        // Descrambler stays in sync across a bypassed beat it received
        do_reset();
        o_rdy = '1;
        for (int k = 0; k < 5; k++) begin
            x = (k == 2) ? {192'd0, BYP_WORD} : rnd();
            h = 2'($urandom_range(0, 3));
            send(0, x, h, 1'b0, scr_model(0, x));
            srcq[0].push_back({h, mask(x, 64)});
        end
        drain(0);
        for (int k = 0; k < 5; k++) begin
            c = cap[0][k];
            s = srcq[0][k];
            send(1, c[255:0], c[257:256], (k == 2), s[255:0]);
        end
        drain(1);
        c = cap[1][4];
        s = srcq[0][4];
        check("dsc_resync", c, s);

        // Reset with two beats buffered
        do_reset();
        o_rdy[0] = 1'b0;
        send(0, rnd(), 2'b01, 1'b0, '0);
        send(0, rnd(), 2'b10, 1'b0, '0);
        @(negedge clk); #1;
        in_v[0] = 1'b0;
        check("full_in_ready", 258'(i_rdy[0]), 258'(0));
        do_reset();
        check("rst_mid_out_valid", 258'(o_v[0]), 258'(0));
        check("rst_mid_in_ready", 258'(i_rdy[0]), 258'(1));
        o_rdy[0] = 1'b1;
        send(0, '0, 2'b01, 1'b0, scr_model(0, '0));
        drain(0);
        c = cap[0][0];
        check("rst_mid_zero_beat", c, {2'b01, 192'd0, ZERO_BEAT});

`ifdef PCS_SCR_SEED_LOAD_EN
        // Loading an all-zero seed makes the scrambler transparent for zeros
        @(negedge clk); #1;
        sl[0] = 1'b1;
        sv[0] = '0;
        @(negedge clk); #1;
        sl[0] = 1'b0;
        model_reset(0, '0);
        cap[0].delete();
        for (int k = 0; k < 3; k++) send(0, '0, 2'b01, 1'b0, scr_model(0, '0));
        drain(0);
        for (int k = 0; k < 3; k++) begin
            c = cap[0][k];
            check($sformatf("seed_zero[%0d]", k), c, {2'b01, 256'd0});
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcs_scrambler_pipe.md
Name: pcs_scrambler_pipe

Overview:
- Parametrised successor to the team's fixed 64-bit descrambler for the 40G/100G PCS datapath, using the same polynomial g(x) = x^58 + x^39 + 1.
- One module covers both scramble (multiplicative) and self-synchronising descramble; the direction is selected by a parameter.
- Data width is configurable; every beat carries a 2-bit sync header and a bypass flag.
- Beats are accepted on a valid/ready handshake and presented through a 2-entry skid buffer, so the block sits directly between the gearbox and the block-lock/decoder stages.

Parameters:
- DATA_WIDTH, 64, payload bits per beat; any value from 8 to 256.
- DESCRAMBLE, 0, 0 = scrambler, 1 = descrambler.
- SEED, 58'h3FF_FFFF_FFFF_FFFF, LFSR state loaded on reset.

Ports:
- CLK  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_WIDTH  payload; bit 0 is first on the wire.
- in_hdr  in  2  sync header; passed through unmodified.
- in_bypass  in  1  pass this beat's payload unscrambled.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  processed payload.
- out_hdr  out  2  header aligned to out_data.

Behaviour:
- Serial model, LSB first, y = scrambled stream.
  - Scrambler: y[n] = x[n] ^ y[n-39] ^ y[n-58].
  - Descrambler: x[n] = y[n] ^ y[n-39] ^ y[n-58].
- State s[57:0] holds the last 58 scrambled bits; s[0] is the most recent.
- Each beat is computed as DATA_WIDTH serial steps unrolled combinationally.
- The state updates only on an accepted beat (in_valid & in_ready).
  - Scrambler: the state absorbs the produced output bits.
  - Descrambler: the state absorbs the received in_data bits.
- in_bypass = 1:
  - out_data = in_data.
  - Scrambler: state is held.
  - Descrambler: state still absorbs in_data (stays self-synchronised).
- Headers are never scrambled.
- Skid FSM has three states:
  - EMPTY: out_valid = 0, in_ready = 1.
  - ONE: output register valid, in_ready = 1.
  - FULL: output register and skid register valid, in_ready = 0.
- Transitions:
  - Accept without pop: EMPTY→ONE, ONE→FULL.
  - Pop without accept: ONE→EMPTY, FULL→ONE (skid moves to the output register).
  - Simultaneous accept and pop in ONE: stay in ONE; the new beat goes to the output register.
- in_ready is a registered decode of the state; there is no combinational path from out_ready to in_ready.
- Latency: an accepted beat appears on out_* the next cycle when the buffer was EMPTY, or was ONE and popped in the same cycle.
- Beat order is preserved. out_* are stable while out_valid & !out_ready.
- Reset values:
  - FSM = EMPTY, out_valid = 0, in_ready = 1 (from the first cycle after reset).
  - out_data = 0, out_hdr = 0, state = SEED.
- Reset mid-operation drops any buffered beats; there is no partial-beat recovery.
- in_valid asserted during rst is ignored.

Optional Feature:
- Macro: PCS_SCR_SEED_LOAD_EN.
- When defined, the block adds two ports:
  - seed_load (in, 1).
  - seed_value (in, 58).
- On seed_load = 1 the state loads seed_value at the clock edge.
  - seed_load takes priority over a same-cycle beat update; that beat is still processed with the old state.
  - The buffers are untouched.
- When undefined, the ports are absent and the state is only loadable by rst.

Decomposition:
- Package pcs_scr_pkg holds:
  - LFSR_WIDTH = 58, TAP_A = 39, TAP_B = 58.
  - SEED_DEFAULT.
  - The skid FSM enum: EMPTY/ONE/FULL.
- Sub-module pcs_scr_lfsr_comb is purely combinational, parametrised by DATA_WIDTH and DESCRAMBLE.
  - Inputs: state_in, data_in.
  - Outputs: data_out, state_out.
- The top level holds the state register, bypass muxing and the skid FSM.

Test Plan:
- Scrambler, DATA_WIDTH = 64, reset then in_data = 0 and in_bypass = 0 → first out_data = 64'h03FF_FF80_0000_0000; out_hdr equals in_hdr (2'b01).
- Scrambler→descrambler loopback with 1000 random beats and random headers → descrambler output equals source from beat 2 onward; beat 1 also matches because both sides use the same SEED.
- out_ready held low for 5 cycles during continuous in_valid → exactly 2 beats buffered, in_ready falls after the second accept, no loss or duplication, order preserved after release.
- Bypass beat with in_data = 64'hDEAD_BEEF_0123_4567 → output is identical. Scrambler's next beat equals its no-bypass result; descrambler stays in sync with a stream that scrambled the bypass beat.
- Assert rst with 2 beats buffered → next cycle out_valid = 0 and in_ready = 1; the following zero beat again yields 64'h03FF_FF80_0000_0000.
- DATA_WIDTH = 32 and 128 loopback, plus PCS_SCR_SEED_LOAD_EN with seed_value = 0 and zero data → scrambler output stays 0.
